mem_wb_stage: RTL and testbench

Memory-access stage plus MEM/WB pipeline register for the five-stage pipeline. It consumes the EX/MEM register outputs, performs data-memory loads and stores with a configurable wait-state FSM that stalls upstream stages, and registers write-back information for the WB stage. It also drives the branch redirect to the fetch stage.

---
 rtl/mem_wb_stage.sv | 114 +++++++++++
 tb/tb_mem_wb_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register with optional wait-state stalling.
// Define MEMWB_STALL_EN to enable the WAIT_CYCLES wait-state FSM; otherwise every access completes in one cycle.
module mem_wb_stage #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mem_wreg,
    input  logic        mem_m2reg,
    input  logic        mem_wmem,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_b,
    input  logic [4:0]  mem_rn,
    input  logic        mem_branch,
    input  logic [31:0] mem_bpc,
    output logic        mem_stall,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        wb_wreg,
    output logic        wb_m2reg,
    output logic [4:0]  wb_rn,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_mdata,
    output logic [31:0] wb_wdata,
    output logic [4:0]  dbg_fsm
);

    logic [31:0]       dmem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] addr;
    logic              access;
    logic              complete;

    assign addr   = mem_alu[ADDR_W+1:2];
    assign access = mem_m2reg | mem_wmem;

`ifdef MEMWB_STALL_EN
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    state_t     state;
    logic [3:0] cnt;

    always_comb begin
        complete = 1'b1;
        if (state == S_WAIT)
            complete = (cnt == WAIT_N);
        else if (access && (WAIT_N != 4'd0))
            complete = 1'b0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else if (state == S_IDLE) begin
            if (!complete) begin
                state <= S_WAIT;
                cnt   <= 4'd1;
            end
        end else if (complete) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    assign dbg_fsm = {state == S_WAIT, cnt};
`else
    logic [3:0] unused_wait;

    // Without wait states the access is single-cycle and the parameter has no effect.
    assign unused_wait = 4'(WAIT_CYCLES);
    assign complete    = 1'b1;
    assign dbg_fsm     = 5'd0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_alu[31:ADDR_W+2], mem_alu[1:0]};

    assign mem_stall   = ~complete;
    assign pc_redirect = mem_branch & ~mem_stall;
    assign redirect_pc = mem_bpc;
    assign wb_wdata    = wb_m2reg ? wb_mdata : wb_alu;

    // Stalled edges insert a bubble by dropping the write-back controls only.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wb_wreg  <= 1'b0;
            wb_m2reg <= 1'b0;
            wb_rn    <= 5'd0;
            wb_alu   <= 32'd0;
            wb_mdata <= 32'd0;
        end else if (complete) begin
            wb_wreg  <= mem_wreg;
            wb_m2reg <= mem_m2reg;
            wb_rn    <= mem_rn;
            wb_alu   <= mem_alu;
            wb_mdata <= dmem[addr];
        end else begin
            wb_wreg  <= 1'b0;
            wb_m2reg <= 1'b0;
        end
    end

    // Store commits once, at completion; the clrn gate keeps reset from landing a pending store.
    always_ff @(posedge clk) begin
        if (complete && mem_wmem && clrn)
            dmem[addr] <= mem_b;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: driver issues EX/MEM instructions, a monitor scores write-backs.
module tb_mem_wb_stage;

`ifdef MEMWB_STALL_EN
    localparam int N = 2;
`else
    localparam int N = 0;
`endif

    logic        clk = 1'b0;
    logic        clrn;
    logic        mem_wreg, mem_m2reg, mem_wmem, mem_branch;
    logic [31:0] mem_alu, mem_b, mem_bpc;
    logic [4:0]  mem_rn;
    logic        mem_stall, pc_redirect, wb_wreg, wb_m2reg;
    logic [31:0] redirect_pc, wb_alu, wb_mdata, wb_wdata;
    logic [4:0]  wb_rn, dbg_fsm;

    int vectors = 0;
    int miscompares = 0;
    logic [36:0] exp_q[$];

    mem_wb_stage #(.ADDR_W(6), .WAIT_CYCLES(2)) dut (
        .clk(clk), .clrn(clrn),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem),
        .mem_alu(mem_alu), .mem_b(mem_b), .mem_rn(mem_rn),
        .mem_branch(mem_branch), .mem_bpc(mem_bpc),
        .mem_stall(mem_stall), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
        .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg), .wb_rn(wb_rn),
        .wb_alu(wb_alu), .wb_mdata(wb_mdata), .wb_wdata(wb_wdata),
        .dbg_fsm(dbg_fsm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        mem_wreg = 1'b0; mem_m2reg = 1'b0; mem_wmem = 1'b0; mem_branch = 1'b0;
        mem_alu = 32'd0; mem_b = 32'd0; mem_bpc = 32'd0; mem_rn = 5'd0;
    endtask

    task automatic check_reset_state();
        check("rst_wb_wreg", 64'(wb_wreg), 64'd0);
        check("rst_wb_m2reg", 64'(wb_m2reg), 64'd0);
        check("rst_wb_rn", 64'(wb_rn), 64'd0);
        check("rst_wb_alu", 64'(wb_alu), 64'd0);
        check("rst_wb_mdata", 64'(wb_mdata), 64'd0);
        check("rst_wb_wdata", 64'(wb_wdata), 64'd0);
        check("rst_mem_stall", 64'(mem_stall), 64'd0);
    endtask

    // Called at posedge+2; returns at posedge+2 after the completion edge.
    task automatic issue(input logic wreg, input logic m2reg, input logic wmem,
                         input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                         input logic br, input logic [31:0] bpc, input logic [31:0] exp_data);
        mem_wreg = wreg; mem_m2reg = m2reg; mem_wmem = wmem; mem_alu = alu;
        mem_b = b; mem_rn = rn; mem_branch = br; mem_bpc = bpc;
        if (wreg) exp_q.push_back({rn, exp_data});
        for (int i = 0; i <= ((m2reg | wmem) ? N : 0); i++) begin
            logic stall_exp;
            stall_exp = (i < ((m2reg | wmem) ? N : 0));
            #1;
            check("mem_stall", 64'(mem_stall), 64'(stall_exp));
            check("pc_redirect", 64'(pc_redirect), 64'(br & ~stall_exp));
            if (br) check("redirect_pc", 64'(redirect_pc), 64'(bpc));
            @(posedge clk);
            #2;
            if (stall_exp) check("bubble_wb_wreg", 64'(wb_wreg), 64'd0);
        end
        clear_inputs();
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (clrn && wb_wreg) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_writeback", 64'({wb_rn, wb_wdata}), 64'd0);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    check("wb_rn", 64'(wb_rn), 64'(e[36:32]));
                    check("wb_wdata", 64'(wb_wdata), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        clear_inputs();
        clrn = 1'b0;
        #3;
        check_reset_state();
        #10;
        clrn = 1'b1;
        @(posedge clk);
        #2;

        issue(1'b0, 1'b0, 1'b1, 32'h10, 32'h5555_5555, 5'd0, 1'b0, 32'd0, 32'd0);
        issue(1'b0, 1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, 5'd0, 1'b0, 32'd0, 32'd0);
        issue(1'b1, 1'b1, 1'b0, 32'h24, 32'd0, 5'd7, 1'b0, 32'd0, 32'hCAFE_F00D);
        issue(1'b1, 1'b0, 1'b0, 32'h1234, 32'd0, 5'd3, 1'b0, 32'd0, 32'h1234);
        issue(1'b0, 1'b0, 1'b1, 32'h100, 32'h11, 5'd0, 1'b0, 32'd0, 32'd0);
        issue(1'b1, 1'b1, 1'b0, 32'h000, 32'd0, 5'd4, 1'b0, 32'd0, 32'h11);
        issue(1'b1, 1'b1, 1'b0, 32'h101, 32'd0, 5'd5, 1'b0, 32'd0, 32'h11);
        issue(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 32'h40, 32'd0);
        issue(1'b1, 1'b1, 1'b0, 32'h24, 32'd0, 5'd6, 1'b1, 32'h80, 32'hCAFE_F00D);

        // Reset while a store to 0x10 is pending; upstream is cleared along with it.
        mem_wmem = 1'b1; mem_alu = 32'h10; mem_b = 32'h0000_DEAD;
        repeat ((N > 0) ? 1 : 0) @(posedge clk);
        #2;
        clrn = 1'b0;
        clear_inputs();
        #1;
        check_reset_state();
        #4;
        clrn = 1'b1;
        @(posedge clk);
        #2;
        issue(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 5'd9, 1'b0, 32'd0, 32'h5555_5555);

        issue(1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 32'd0, 5'd1, 1'b0, 32'd0, 32'hA5A5_0001);
        issue(1'b1, 1'b0, 1'b0, 32'h0000_0BEE, 32'd0, 5'd2, 1'b0, 32'd0, 32'h0000_0BEE);
        repeat (3) @(posedge clk);
        #2;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
